sfp_writeback: RTL and testbench

- Stage directly downstream of the SFP accumulator lanes.
- Takes one flushed accumulation vector per transfer (col lanes × psum_bw), optionally applies ReLU, and buffers it in a 2-entry FIFO.
- Writes each vector as one word to the output/psum SRAM at consecutive addresses.
- A start/done FSM sequences one writeback job of num_words vectors per start.

---
 rtl/sfp_writeback.sv | 183 ++++++++++++++++++
 tb/tb_sfp_writeback.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_writeback.sv
// sfp_writeback
//   Writeback stage that sits directly downstream of the SFP accumulator lanes.
//   Each accepted vector holds col lanes of psum_bw bits. It is buffered in a
//   2-entry FIFO and written as one SRAM word at consecutive addresses. A
//   start/done FSM runs one job of num_words vectors per start pulse.
//
// Configuration macro:
//   SFP_RELU_EN - when defined, negative lanes are clamped to zero before the
//                 FIFO push. When undefined, lanes pass through unchanged.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   asynchronous active-low reset
//   start      in   job start pulse, only sampled in IDLE
//   base_addr  in   first SRAM address of the job, latched on start
//   num_words  in   number of vectors in the job, latched on start
//   in_valid   in   flushed vector valid from the SFP lanes
//   in_ready   out  stage accepts a vector this cycle
//   in_data    in   lane k at bits [k*psum_bw +: psum_bw], signed
//   mem_ready  in   SRAM can take a write this cycle
//   mem_wr     out  SRAM write strobe
//   mem_addr   out  SRAM write address
//   mem_data   out  SRAM write data (FIFO head)
//   busy       out  job in progress (FSM not IDLE)
//   done       out  one-cycle pulse at job completion
module sfp_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [addr_bw:0]         num_words,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [col*psum_bw-1:0]   in_data,
  input  logic                     mem_ready,
  output logic                     mem_wr,
  output logic [addr_bw-1:0]       mem_addr,
  output logic [col*psum_bw-1:0]   mem_data,
  output logic                     busy,
  output logic                     done
);

  localparam int VW = col * psum_bw;
  localparam logic [addr_bw:0]   CNT_ONE = 1;
  localparam logic [addr_bw-1:0] PTR_ONE = 1;
  localparam logic [1:0]         FIFO_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [addr_bw:0]   r_target;
  logic [addr_bw:0]   r_acc_cnt;
  logic [addr_bw:0]   r_wr_cnt;
  logic [addr_bw-1:0] r_wr_ptr;

  logic [VW-1:0]      r_fifo [2];
  logic               r_fifo_wp;
  logic               r_fifo_rp;
  logic [1:0]         r_fifo_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_start;
  logic [VW-1:0]      w_lane_data;

  assign w_full   = (r_fifo_cnt == FIFO_DEPTH);
  assign w_empty  = (r_fifo_cnt == 2'd0);
  assign w_start  = (r_state == IDLE) && start;

  // in_ready looks only at registered occupancy, so a full FIFO blocks input
  // even in a cycle where the head is being popped.
  assign in_ready = (r_state == RUN) && !w_full && (r_acc_cnt < r_target);
  assign mem_wr   = (r_state == RUN) && !w_empty && mem_ready;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = mem_wr;

  assign mem_data = r_fifo[r_fifo_rp];
  assign mem_addr = r_wr_ptr;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);

  // Per-lane transform applied on the way into the FIFO.
  always_comb begin
    w_lane_data = in_data;
`ifdef SFP_RELU_EN
    for (int k = 0; k < col; k++) begin
      if (in_data[k*psum_bw + psum_bw - 1]) begin
        w_lane_data[k*psum_bw +: psum_bw] = '0;
      end
    end
`endif
  end

  // Next-state logic. RUN leaves once the registered write count has met the
  // target, so DONE follows the cycle after the last write has landed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = (num_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (r_wr_cnt == r_target) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Job counters and the SRAM write pointer. The pointer wraps naturally at
  // 2^addr_bw.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_target  <= '0;
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
      r_wr_ptr  <= '0;
    end else if (w_start) begin
      r_target  <= num_words;
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
      r_wr_ptr  <= base_addr;
    end else begin
      if (w_push) begin
        r_acc_cnt <= r_acc_cnt + CNT_ONE;
      end
      if (w_pop) begin
        r_wr_cnt <= r_wr_cnt + CNT_ONE;
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
    end
  end

  // Two-entry FIFO with one-bit read/write pointers and an occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo[i] <= '0;
      end
      r_fifo_wp  <= 1'b0;
      r_fifo_rp  <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_fifo_wp] <= w_lane_data;
        r_fifo_wp         <= ~r_fifo_wp;
      end
      if (w_pop) begin
        r_fifo_rp <= ~r_fifo_rp;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_writeback.sv
// Testbench for sfp_writeback: a queue-based job model checked every cycle,
// directed jobs pinned with literal addresses/data, then randomized jobs.
module tb_sfp_writeback;

  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int ABW = 4;
  localparam int VW  = COL * PBW;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [ABW-1:0] base_addr = '0;
  logic [ABW:0]   num_words = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [VW-1:0]  in_data = '0;
  logic           mem_ready = 1'b0;
  logic           mem_wr;
  logic [ABW-1:0] mem_addr;
  logic [VW-1:0]  mem_data;
  logic           busy;
  logic           done;

  int compCount = 0;
  int failCount = 0;

  // Model: job phase (0 idle, 1 running, 2 finishing), pending words, counts.
  int            mMode = 0;
  int            mAcc = 0;
  int            mWr = 0;
  int            mTarget = 0;
  int            mAddr = 0;
  int            mAccTotal = 0;
  logic [VW-1:0] mq[$];
  bit            eReady;
  bit            eWr;

  int            logAddr[$];
  logic [VW-1:0] logData[$];
  int            logCyc[$];
  int            cycle = 0;
  int            doneSeen = 0;

  sfp_writeback #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_ready(mem_ready), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    compCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] xform(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
`ifdef SFP_RELU_EN
    for (int k = 0; k < COL; k++) begin
      if ($signed(v[k*PBW +: PBW]) < 0) r[k*PBW +: PBW] = '0;
    end
`endif
    return r;
  endfunction

  function automatic logic [VW-1:0] randVec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int logA(input int i);
    return (i < logAddr.size()) ? logAddr[i] : -1;
  endfunction

  function automatic logic [VW-1:0] logD(input int i);
    return (i < logData.size()) ? logData[i] : 'x;
  endfunction

  function automatic int logC(input int i);
    return (i < logCyc.size()) ? logCyc[i] : -100;
  endfunction

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
    logCyc.delete();
  endtask

  // Compare process: check the current cycle, then advance the model to the
  // state it must hold after the coming rising edge.
  always @(negedge clk) begin
    #2;
    cycle++;
    if (!reset) begin
      mMode = 0; mAcc = 0; mWr = 0; mTarget = 0; mAddr = 0;
      mq.delete();
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_mem_wr", mem_wr, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_data", mem_data, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
    end else begin
      eReady = (mMode == 1) && (mq.size() < 2) && (mAcc < mTarget);
      eWr    = (mMode == 1) && (mq.size() > 0) && mem_ready;
      checkOutput("in_ready", in_ready, eReady);
      checkOutput("mem_wr", mem_wr, eWr);
      checkOutput("busy", busy, mMode != 0);
      checkOutput("done", done, mMode == 2);
      if (eWr) begin
        checkOutput("mem_addr", mem_addr, mAddr);
        checkOutput("mem_data", mem_data, mq[0]);
        logAddr.push_back(mAddr);
        logData.push_back(mq[0]);
        logCyc.push_back(cycle);
      end
      if (done) doneSeen++;
      case (mMode)
        0: begin
          if (start) begin
            mAddr = int'(base_addr);
            mTarget = int'(num_words);
            mAcc = 0;
            mWr = 0;
            mMode = (num_words == 0) ? 2 : 1;
          end
        end
        1: begin
          if (mWr == mTarget) mMode = 2;
          if (eWr) begin
            void'(mq.pop_front());
            mAddr = (mAddr + 1) % 16;
            mWr++;
          end
          if (eReady && in_valid) begin
            mq.push_back(xform(in_data));
            mAcc++;
            mAccTotal++;
          end
        end
        default: mMode = 0;
      endcase
    end
  end

  task automatic startJob(input int b, input int n);
    @(negedge clk);
    start = 1'b1;
    base_addr = b[ABW-1:0];
    num_words = n[ABW:0];
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    base_addr = ABW'($urandom);
    num_words = (ABW+1)'($urandom);
  endtask

  // Drive random handshakes until the DUT reports done or the budget expires.
  task automatic applyStimulus(input int vPct, input int rPct, input int maxCyc);
    int  d0;
    bit  finished;
    d0 = doneSeen;
    finished = 1'b0;
    for (int c = 0; c < maxCyc; c++) begin
      @(negedge clk);
      if (doneSeen != d0) begin
        finished = 1'b1;
        break;
      end
      in_valid  = ($urandom_range(99, 0) < vPct);
      mem_ready = ($urandom_range(99, 0) < rPct);
      in_data   = randVec();
    end
    in_valid  = 1'b0;
    mem_ready = 1'b1;
    checkOutput("job_finished", finished, 1);
  endtask

  initial begin
    int            d0;
    int            a0;
    int            n;
    logic [VW-1:0] vec;
    logic [VW-1:0] got;
    logic [VW-1:0] expVec;

    repeat (3) @(negedge clk);
    #3;
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic job: 3 words from address 2, full throughput.
    clearLog();
    d0 = doneSeen;
    startJob(2, 3);
    applyStimulus(100, 100, 40);
    checkOutput("basic_count", logAddr.size(), 3);
    checkOutput("basic_a0", logA(0), 2);
    checkOutput("basic_a1", logA(1), 3);
    checkOutput("basic_a2", logA(2), 4);
    checkOutput("basic_consecutive", logC(2) - logC(0), 2);
    checkOutput("basic_done_once", doneSeen - d0, 1);
    #3;
    checkOutput("basic_busy_low", busy, 0);

    // Lane transform with mixed-sign lanes.
    clearLog();
    vec = {16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h0100, 16'hABCD, 16'h0007, 16'hFFFB};
`ifdef SFP_RELU_EN
    expVec = {16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0007, 16'h0000};
`else
    expVec = vec;
`endif
    startJob(0, 1);
    @(negedge clk);
    in_valid = 1'b1; mem_ready = 1'b1; in_data = vec;
    @(negedge clk);
    in_valid = 1'b0;
    applyStimulus(0, 100, 20);
    got = logD(0);
`ifdef SFP_RELU_EN
    checkOutput("relu_lane0", got[15:0], 16'h0000);
`else
    checkOutput("relu_lane0", got[15:0], 16'hFFFB);
`endif
    checkOutput("relu_lane1", got[31:16], 16'h0007);
    checkOutput("relu_vector", got, expVec);

    // Backpressure: SRAM stalled while input is offered.
    clearLog();
    startJob(0, 4);
    a0 = mAccTotal;
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1; mem_ready = 1'b0; in_data = randVec();
    end
    #3;
    checkOutput("bp_accepted", mAccTotal - a0, 2);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_mem_wr", mem_wr, 0);
    applyStimulus(100, 100, 40);
    checkOutput("bp_count", logAddr.size(), 4);
    checkOutput("bp_a3", logA(3), 3);

    // Address wrap and overrun.
    clearLog();
    startJob(14, 4);
    a0 = mAccTotal;
    applyStimulus(100, 100, 40);
    checkOutput("wrap_a0", logA(0), 14);
    checkOutput("wrap_a1", logA(1), 15);
    checkOutput("wrap_a2", logA(2), 0);
    checkOutput("wrap_a3", logA(3), 1);
    checkOutput("wrap_accepted", mAccTotal - a0, 4);

    // Zero-length job.
    clearLog();
    d0 = doneSeen;
    startJob(6, 0);
    #3;
    checkOutput("zero_done_now", done, 1);
    checkOutput("zero_done_count", doneSeen - d0, 1);
    @(negedge clk);
    in_valid = 1'b1;
    #3;
    checkOutput("zero_done_gone", done, 0);
    checkOutput("zero_no_writes", logAddr.size(), 0);
    in_valid = 1'b0;

    // Start during RUN is ignored.
    clearLog();
    d0 = doneSeen;
    startJob(5, 2);
    @(negedge clk);
    start = 1'b1; base_addr = 4'd9; num_words = 5'd7;
    in_valid = 1'b1; mem_ready = 1'b1; in_data = randVec();
    @(negedge clk);
    start = 1'b0;
    applyStimulus(100, 100, 40);
    checkOutput("ign_count", logAddr.size(), 2);
    checkOutput("ign_a0", logA(0), 5);
    checkOutput("ign_a1", logA(1), 6);
    checkOutput("ign_done", doneSeen - d0, 1);

    // Asynchronous reset with one vector buffered.
    startJob(3, 3);
    @(negedge clk);
    in_valid = 1'b1; mem_ready = 1'b0; in_data = randVec();
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    checkOutput("pre_rst_addr", mem_addr, 3);
    checkOutput("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    checkOutput("arst_in_ready", in_ready, 0);
    checkOutput("arst_mem_wr", mem_wr, 0);
    checkOutput("arst_mem_addr", mem_addr, 0);
    checkOutput("arst_mem_data", mem_data, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    d0 = doneSeen;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    checkOutput("arst_no_done", doneSeen - d0, 0);
    clearLog();
    startJob(7, 2);
    applyStimulus(100, 100, 40);
    checkOutput("post_rst_a0", logA(0), 7);
    checkOutput("post_rst_a1", logA(1), 8);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      clearLog();
      n = (j == 4) ? 0 : $urandom_range(16, 1);
      startJob($urandom_range(15, 0), n);
      applyStimulus($urandom_range(100, 30), $urandom_range(100, 30), 400);
      checkOutput("rnd_count", logAddr.size(), n);
      repeat (3) begin
        @(negedge clk);
        in_valid = 1'(($urandom));
        in_data = randVec();
      end
      in_valid = 1'b0;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
